// File: rtl/adaptive_ctrl_pkg.sv
// Shared types and the mode-selection rule for the adaptive control unit's issue stage.
package adaptive_ctrl_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic {
    MODE_LOW_POWER = 1'b0,
    MODE_HIGH_PERF = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } issue_state_e;

  // Requested mode wins when auto is off. Otherwise backlog forces HighPerf
  // before a long idle period is allowed to drop back to LowPower.
  function automatic mode_e select_target(
    input logic  auto_en,
    input logic  mode_req,
    input logic  half_full,
    input logic  idle_expired,
    input mode_e cur_mode
  );
    mode_e tgt;
    if (!auto_en) begin
      tgt = mode_e'(mode_req);
    end else if (half_full) begin
      tgt = MODE_HIGH_PERF;
    end else if (idle_expired) begin
      tgt = MODE_LOW_POWER;
    end else begin
      tgt = cur_mode;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous FIFO holding pending instructions; head is readable combinationally
// so the sequencer can register it into its opcode output on the pop edge.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered count, so a same-cycle pop never frees the slot.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Buffers producer instructions and issues one per cycle, quiescing the stream
// (DRAIN then SWITCH) before any LowPower/HighPerf mode change takes effect.
module instr_issue_sequencer
  import adaptive_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int IDLE_LIMIT   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [OPCODE_W-1:0]          in_opcode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode_req,
  input  logic                         auto_en,
  output logic [OPCODE_W-1:0]          opcode,
  output logic                         valid,
  output logic                         mode,
  output logic                         stall,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IDLE_LIMIT + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  issue_state_e        state_q, state_d;
  mode_e               mode_q, mode_d;
  mode_e               tgt_q, tgt_d;
  mode_e               target;
  logic                valid_q, valid_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;

  logic                push;
  logic                pop;
  logic [OPCODE_W-1:0] fifo_rdata;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drain_done;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPCODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_opcode),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign fifo_count = fifo_cnt;
  assign drain_done = (drain_cnt_q == DW'(DRAIN_CYCLES - 1));

  assign target = select_target(auto_en, mode_req,
                                fifo_cnt >= CW'(DEPTH / 2),
                                idle_cnt_q == IW'(IDLE_LIMIT),
                                mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mode_q      <= MODE_LOW_POWER;
      tgt_q       <= MODE_LOW_POWER;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      idle_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      tgt_q       <= tgt_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      idle_cnt_q  <= idle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (target != mode_q) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = SWITCH;
      SWITCH:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    valid_d     = 1'b0;
    opcode_d    = opcode_q;
    pop         = 1'b0;
    tgt_d       = tgt_q;
    mode_d      = mode_q;
    drain_cnt_d = drain_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    stall       = (state_q != RUN);

    case (state_q)
      RUN: begin
        // A pending mode change blocks issue even with work queued.
        if (target != mode_q) begin
          tgt_d       = target;
          drain_cnt_d = '0;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          opcode_d = fifo_rdata;
          valid_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (!drain_done) begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      SWITCH: begin
        mode_d = tgt_q;
      end
      default: begin
        mode_d = mode_q;
      end
    endcase

    if (push) begin
      idle_cnt_d = '0;
    end else if (state_q == RUN && fifo_empty && !in_valid &&
                 idle_cnt_q != IW'(IDLE_LIMIT)) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  assign valid  = valid_q;
  assign opcode = opcode_q;
  assign mode   = mode_q;

endmodule
